// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for a 5-stage pipeline
//   Detects load-use hazards between ID and EX and inserts one bubble.
//   Turns taken-branch redirects from EX into IF/ID and ID/EX flushes.
//   Freezes the pipeline while a data memory access waits for its ack.
//   A wait that runs too long latches a sticky bus error until reset.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   id_rs1_i/id_rs2_i(+_used_i)  source registers read by the ID instruction
//   ex_rd_i, ex_is_load_i        destination and load flag of the EX instruction
//   ex_branch_taken_i            EX resolved a taken branch or jump
//   mem_req_i, dmem_ack_i        memory access pending / completed this cycle
//   dmem_req_o                   request to data memory
//   stall_if_o/stall_id_o/stall_em_o, bubble_ex_o, flush_id_o, flush_ex_o
//   bus_err_o, state_o           sticky timeout flag, FSM state (RUN=0, MEM_WAIT=1, ERROR=2)
// Optional: define PIPE_HAZARD_CTRL_PERF_EN to add the 32-bit stall and flush counters
//   perf_stall_cnt_o and perf_flush_cnt_o.
module pipe_hazard_ctrl #(
   parameter int REG_ADDR_W  = 5,
   parameter int MEM_TIMEOUT = 200,
   parameter int TO_W        = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [REG_ADDR_W-1:0] id_rs1_i,
   input  logic [REG_ADDR_W-1:0] id_rs2_i,
   input  logic                  id_rs1_used_i,
   input  logic                  id_rs2_used_i,
   input  logic [REG_ADDR_W-1:0] ex_rd_i,
   input  logic                  ex_is_load_i,
   input  logic                  ex_branch_taken_i,
   input  logic                  mem_req_i,
   input  logic                  dmem_ack_i,
   output logic                  dmem_req_o,
   output logic                  stall_if_o,
   output logic                  stall_id_o,
   output logic                  stall_em_o,
   output logic                  bubble_ex_o,
   output logic                  flush_id_o,
   output logic                  flush_ex_o,
   output logic                  bus_err_o,
   output logic [1:0]            state_o
`ifdef PIPE_HAZARD_CTRL_PERF_EN
   ,
   output logic [31:0]           perf_stall_cnt_o,
   output logic [31:0]           perf_flush_cnt_o
`endif
);
   localparam logic [1:0] S_RUN  = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_ERR  = 2'd2;
   logic [1:0]      r_state;
   logic [1:0]      w_next;
   logic [TO_W-1:0] r_to_cnt;
   logic [TO_W-1:0] w_to_next;
   logic            w_miss;
   logic            w_hazard;
   // An access that is not acknowledged in the cycle it is issued must wait.
   assign w_miss   = mem_req_i & ~dmem_ack_i;
   // A zero destination never creates a dependency.
   assign w_hazard = ex_is_load_i & (ex_rd_i != '0) &
                     ((id_rs1_used_i & (id_rs1_i == ex_rd_i)) |
                      (id_rs2_used_i & (id_rs2_i == ex_rd_i)));
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= S_RUN;
         r_to_cnt <= '0;
      end else begin
         r_state  <= w_next;
         r_to_cnt <= w_to_next;
      end
   end
   // An ack in the final timeout cycle still completes the access.
   always_comb begin
      w_next    = S_RUN;
      w_to_next = r_to_cnt;
      case (r_state)
         S_WAIT: begin
            if (dmem_ack_i) begin
               w_next = S_RUN;
            end else if (r_to_cnt == TO_W'(MEM_TIMEOUT - 1)) begin
               w_next = S_ERR;
            end else begin
               w_next    = S_WAIT;
               w_to_next = r_to_cnt + 1'b1;
            end
         end
         S_ERR: w_next = S_ERR;
         default: begin
            if (w_miss) begin
               w_next    = S_WAIT;
               w_to_next = '0;
            end
         end
      endcase
   end
   // The unused encoding 3 behaves and reports as RUN.
   always_comb begin
      dmem_req_o  = 1'b0;
      stall_if_o  = 1'b0;
      stall_id_o  = 1'b0;
      stall_em_o  = 1'b0;
      bubble_ex_o = 1'b0;
      flush_id_o  = 1'b0;
      flush_ex_o  = 1'b0;
      bus_err_o   = 1'b0;
      state_o     = 2'd0;
      if (!rst_i) begin
         state_o = (r_state == 2'd3) ? S_RUN : r_state;
         case (r_state)
            S_WAIT: begin
               dmem_req_o = 1'b1;
               stall_if_o = 1'b1;
               stall_id_o = 1'b1;
               stall_em_o = 1'b1;
            end
            S_ERR: begin
               bus_err_o  = 1'b1;
               stall_if_o = 1'b1;
               stall_id_o = 1'b1;
               stall_em_o = 1'b1;
            end
            default: begin
               dmem_req_o = mem_req_i;
               if (w_miss) begin
                  stall_if_o = 1'b1;
                  stall_id_o = 1'b1;
                  stall_em_o = 1'b1;
               end else if (ex_branch_taken_i) begin
                  flush_id_o = 1'b1;
                  flush_ex_o = 1'b1;
               end else if (w_hazard) begin
                  stall_if_o  = 1'b1;
                  stall_id_o  = 1'b1;
                  bubble_ex_o = 1'b1;
               end
            end
         endcase
      end
   end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_stall_cnt <= r_stall_cnt + 32'(stall_if_o);
         r_flush_cnt <= r_flush_cnt + 32'(flush_ex_o);
      end
   end
   assign perf_stall_cnt_o = r_stall_cnt;
   assign perf_flush_cnt_o = r_flush_cnt;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and randomized checks of pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;
   localparam int RW  = 5;
   localparam int TMO = 4;
   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [RW-1:0] id_rs1_i, id_rs2_i, ex_rd_i;
   logic          id_rs1_used_i, id_rs2_used_i, ex_is_load_i, ex_branch_taken_i;
   logic          mem_req_i, dmem_ack_i;
   logic          dmem_req_o, stall_if_o, stall_id_o, stall_em_o;
   logic          bubble_ex_o, flush_id_o, flush_ex_o, bus_err_o;
   logic [1:0]    state_o;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
   logic [31:0]   perf_stall_cnt_o, perf_flush_cnt_o;
`endif
   logic [9:0]    w_vec;
   int            checks = 0;
   int            errors = 0;
   bit            chk_en = 1'b0;
   int            m_mode = 0;
   int            m_k = 0;
   logic [31:0]   m_stall = '0;
   logic [31:0]   m_flush = '0;

   pipe_hazard_ctrl #(.REG_ADDR_W(RW), .MEM_TIMEOUT(TMO), .TO_W(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
      .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
      .ex_rd_i(ex_rd_i), .ex_is_load_i(ex_is_load_i),
      .ex_branch_taken_i(ex_branch_taken_i),
      .mem_req_i(mem_req_i), .dmem_ack_i(dmem_ack_i),
      .dmem_req_o(dmem_req_o), .stall_if_o(stall_if_o), .stall_id_o(stall_id_o),
      .stall_em_o(stall_em_o), .bubble_ex_o(bubble_ex_o),
      .flush_id_o(flush_id_o), .flush_ex_o(flush_ex_o),
      .bus_err_o(bus_err_o), .state_o(state_o)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      , .perf_stall_cnt_o(perf_stall_cnt_o), .perf_flush_cnt_o(perf_flush_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   assign w_vec = {dmem_req_o, stall_if_o, stall_id_o, stall_em_o, bubble_ex_o,
                   flush_id_o, flush_ex_o, bus_err_o, state_o};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected {dmem_req, stall_if, stall_id, stall_em, bubble, flush_id, flush_ex, bus_err, state}
   function automatic logic [9:0] model_out();
      logic haz;
      haz = ex_is_load_i && (ex_rd_i != 0) &&
            ((id_rs1_used_i && id_rs1_i == ex_rd_i) || (id_rs2_used_i && id_rs2_i == ex_rd_i));
      if (rst_i) return 10'b0;
      if (m_mode == 2) return 10'b0111000110;
      if (m_mode == 1) return 10'b1111000001;
      if (mem_req_i && !dmem_ack_i) return 10'b1111000000;
      if (ex_branch_taken_i) return {mem_req_i, 3'b000, 1'b0, 2'b11, 3'b000};
      if (haz) return {mem_req_i, 3'b110, 1'b1, 5'b00000};
      return {mem_req_i, 9'b0};
   endfunction

   // m_k is the 1-based index of the current wait cycle.
   always @(posedge clk_i) begin
      automatic logic [9:0] e = model_out();
      if (rst_i) begin
         m_mode  <= 0;
         m_k     <= 0;
         m_stall <= '0;
         m_flush <= '0;
      end else begin
         m_stall <= m_stall + 32'(e[8]);
         m_flush <= m_flush + 32'(e[3]);
         if (m_mode == 0 && mem_req_i && !dmem_ack_i) begin
            m_mode <= 1;
            m_k    <= 1;
         end else if (m_mode == 1) begin
            if (dmem_ack_i) m_mode <= 0;
            else if (m_k == TMO) m_mode <= 2;
            else m_k <= m_k + 1;
         end
      end
   end

   always @(negedge clk_i) begin
      if (chk_en) begin
         chk("outs", 32'(w_vec), 32'(model_out()));
`ifdef PIPE_HAZARD_CTRL_PERF_EN
         chk("perf_stall", perf_stall_cnt_o, m_stall);
         chk("perf_flush", perf_flush_cnt_o, m_flush);
`endif
      end
   end

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clr();
      id_rs1_i = '0; id_rs2_i = '0; ex_rd_i = '0;
      id_rs1_used_i = 1'b0; id_rs2_used_i = 1'b0; ex_is_load_i = 1'b0;
      ex_branch_taken_i = 1'b0; mem_req_i = 1'b0; dmem_ack_i = 1'b0;
   endtask

   initial begin
      clr();
      rst_i = 1'b1;
      cyc();
      #1 chk("rst_outs_zero", 32'(w_vec), 0);
      cyc();
      rst_i = 1'b0;
      chk_en = 1'b1;
      #1 chk("rst_state", 32'(state_o), 0);
      // load-use hazard, then same registers with rd=0
      cyc();
      ex_is_load_i = 1'b1; ex_rd_i = 5; id_rs1_i = 5; id_rs1_used_i = 1'b1;
      #1 chk("lu_stall_if", 32'(stall_if_o), 1);
      chk("lu_stall_id", 32'(stall_id_o), 1);
      chk("lu_bubble", 32'(bubble_ex_o), 1);
      chk("lu_stall_em", 32'(stall_em_o), 0);
      cyc();
      ex_rd_i = 0; id_rs1_i = 0;
      #1 chk("lu_rd0_stall", 32'(stall_if_o), 0);
      chk("lu_rd0_bubble", 32'(bubble_ex_o), 0);
      // branch beats load-use
      cyc();
      ex_rd_i = 5; id_rs1_i = 5; ex_branch_taken_i = 1'b1;
      #1 chk("br_flush_id", 32'(flush_id_o), 1);
      chk("br_flush_ex", 32'(flush_ex_o), 1);
      chk("br_bubble", 32'(bubble_ex_o), 0);
      chk("br_stall_if", 32'(stall_if_o), 0);
      cyc();
      clr();
      // memory wait, ack in the 4th (final-timeout) wait cycle
      cyc();
      mem_req_i = 1'b1;
      #1 chk("mw_issue_state", 32'(state_o), 0);
      chk("mw_issue_stall_em", 32'(stall_em_o), 1);
      for (int i = 1; i <= 4; i++) begin
         cyc();
         dmem_ack_i = (i == 4);
         #1 chk("mw_state", 32'(state_o), 1);
         chk("mw_stall_if", 32'(stall_if_o), 1);
         chk("mw_dmem_req", 32'(dmem_req_o), 1);
      end
      cyc();
      clr();
      #1 chk("mw_done_state", 32'(state_o), 0);
      chk("mw_done_err", 32'(bus_err_o), 0);
      chk("mw_done_stall", 32'(stall_if_o), 0);
      // zero-wait access
      cyc();
      mem_req_i = 1'b1; dmem_ack_i = 1'b1;
      #1 chk("zw_dmem_req", 32'(dmem_req_o), 1);
      chk("zw_stall", 32'(stall_if_o), 0);
      cyc();
      clr();
      #1 chk("zw_state", 32'(state_o), 0);
      // timeout to ERROR, ack ignored there
      cyc();
      mem_req_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         cyc();
         #1 chk("to_wait_state", 32'(state_o), 1);
      end
      cyc();
      #1 chk("to_err_state", 32'(state_o), 2);
      chk("to_bus_err", 32'(bus_err_o), 1);
      chk("to_dmem_req", 32'(dmem_req_o), 0);
      dmem_ack_i = 1'b1;
      cyc();
      #1 chk("to_err_sticky", 32'(state_o), 2);
      rst_i = 1'b1;
      cyc();
      rst_i = 1'b0; dmem_ack_i = 1'b0;
      #1 chk("to_rst_state", 32'(state_o), 0);
      chk("to_rst_err", 32'(bus_err_o), 0);
      // reset in the 2nd wait cycle, counter restarts afterwards
      cyc();
      cyc();
      #1 chk("rw_wait2_state", 32'(state_o), 1);
      rst_i = 1'b1;
      #1 chk("rw_rst_dmem", 32'(dmem_req_o), 0);
      chk("rw_rst_outs", 32'(w_vec), 0);
      cyc();
      rst_i = 1'b0;
      #1 chk("rw_after_state", 32'(state_o), 0);
      for (int i = 1; i <= 4; i++) begin
         cyc();
         #1 chk("rw_rewait_state", 32'(state_o), 1);
      end
      cyc();
      #1 chk("rw_err_state", 32'(state_o), 2);
      rst_i = 1'b1;
      cyc();
      // branch held through a wait: one flush after the ack
      rst_i = 1'b0; mem_req_i = 1'b1; ex_branch_taken_i = 1'b1;
      #1 chk("bw_issue_flush", 32'(flush_ex_o), 0);
      for (int i = 1; i <= 3; i++) begin
         cyc();
         dmem_ack_i = (i == 3);
         #1 chk("bw_wait_flush", 32'(flush_ex_o), 0);
      end
      cyc();
      mem_req_i = 1'b0; dmem_ack_i = 1'b0;
      #1 chk("bw_flush_ex", 32'(flush_ex_o), 1);
      chk("bw_flush_id", 32'(flush_id_o), 1);
      cyc();
      ex_branch_taken_i = 1'b0;
      #1 chk("bw_after_flush", 32'(flush_ex_o), 0);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      chk("bw_perf_flush", perf_flush_cnt_o, 1);
      chk("bw_perf_stall", perf_stall_cnt_o, 4);
`endif
      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         cyc();
         rst_i = ($urandom_range(63) == 0);
         mem_req_i = ($urandom_range(3) == 0);
         dmem_ack_i = ($urandom_range(2) == 0);
         ex_branch_taken_i = ($urandom_range(5) == 0);
         ex_is_load_i = $urandom_range(1);
         ex_rd_i = RW'($urandom_range(3));
         id_rs1_i = RW'($urandom_range(3));
         id_rs2_i = RW'($urandom_range(3));
         id_rs1_used_i = $urandom_range(1);
         id_rs2_used_i = $urandom_range(1);
      end
      cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
